// File: rtl/alu_exec_if.sv
// Handshake bundle for alu_exec_unit: operation request in, registered result and flags out.
// The master modport is the upstream/downstream side; the slave modport is the execution unit.
interface alu_exec_if #(
    parameter int XLEN = 32
);
    logic            in_valid;
    logic            in_ready;
    logic [3:0]      alu_sel;
    logic [XLEN-1:0] op_a;
    logic [XLEN-1:0] op_b;
    logic            out_valid;
    logic            out_ready;
    logic [XLEN-1:0] result;
    logic            zero;
    logic            carry;
    logic            overflow;
    logic            sign;
    logic            busy;

    modport master (
        output in_valid, alu_sel, op_a, op_b, out_ready,
        input  in_ready, out_valid, result, zero, carry, overflow, sign, busy
    );

    modport slave (
        input  in_valid, alu_sel, op_a, op_b, out_ready,
        output in_ready, out_valid, result, zero, carry, overflow, sign, busy
    );
endinterface

// File: rtl/alu_exec_unit.sv
// ALU execution unit: IDLE -> (EXEC) -> DONE, result and flags held until accepted downstream.
// Define ALU_FAST_SHIFT_EN for a single-cycle barrel shifter; default shifts iteratively 1 bit/cycle.
package alu_exec_pkg;
    typedef enum logic [3:0] {
        ALU_ADD  = 4'h0,
        ALU_SUB  = 4'h1,
        ALU_SLL  = 4'h2,
        ALU_SLT  = 4'h3,
        ALU_SLTU = 4'h4,
        ALU_XOR  = 4'h5,
        ALU_SRL  = 4'h6,
        ALU_SRA  = 4'h7,
        ALU_OR   = 4'h8,
        ALU_AND  = 4'h9,
        ALU_PASS = 4'hA
    } alu_op_e;
endpackage

module alu_exec_unit #(
    parameter int XLEN = 32,
    parameter int SHW  = $clog2(XLEN)
) (
    input logic       clk,
    input logic       rst_n,
    alu_exec_if.slave bus
);
    import alu_exec_pkg::*;

    typedef enum logic [1:0] {S_IDLE, S_EXEC, S_DONE} state_e;

    state_e          state_q, state_d;
    logic [XLEN-1:0] result_q, result_d;
    logic            zero_q, zero_d, carry_q, carry_d, overflow_q, overflow_d, sign_q, sign_d;
    logic            out_valid_q, out_valid_d, busy_q, busy_d, in_ready_q, in_ready_d;
    logic            load;

    logic [XLEN-1:0] a, b;
    logic [SHW-1:0]  shamt;
    logic [XLEN:0]   sum, diff;
    logic [XLEN-1:0] alu_res;
    logic            alu_c, alu_v;

    assign a     = bus.op_a;
    assign b     = bus.op_b;
    assign shamt = b[SHW-1:0];

    // Single-cycle datapath; carry of SUB is the inverted borrow out of the extended difference.
    always_comb begin
        sum     = {1'b0, a} + {1'b0, b};
        diff    = {1'b0, a} - {1'b0, b};
        alu_res = '0;
        alu_c   = 1'b0;
        alu_v   = 1'b0;
        case (bus.alu_sel)
            ALU_ADD: begin
                alu_res = sum[XLEN-1:0];
                alu_c   = sum[XLEN];
                alu_v   = (a[XLEN-1] == b[XLEN-1]) && (sum[XLEN-1] != a[XLEN-1]);
            end
            ALU_SUB: begin
                alu_res = diff[XLEN-1:0];
                alu_c   = ~diff[XLEN];
                alu_v   = (a[XLEN-1] != b[XLEN-1]) && (diff[XLEN-1] != a[XLEN-1]);
            end
            ALU_SLT:  alu_res = {{(XLEN-1){1'b0}}, ($signed(a) < $signed(b))};
            ALU_SLTU: alu_res = {{(XLEN-1){1'b0}}, (a < b)};
            ALU_AND:  alu_res = a & b;
            ALU_OR:   alu_res = a | b;
            ALU_XOR:  alu_res = a ^ b;
            ALU_PASS: alu_res = b;
`ifdef ALU_FAST_SHIFT_EN
            ALU_SLL:  alu_res = a << shamt;
            ALU_SRL:  alu_res = a >> shamt;
            ALU_SRA:  alu_res = $unsigned($signed(a) >>> shamt);
`else
            // Only a zero shift amount completes here; anything else goes through EXEC.
            ALU_SLL, ALU_SRL, ALU_SRA: alu_res = a;
`endif
            default: ;
        endcase
    end

`ifndef ALU_FAST_SHIFT_EN
    logic [XLEN-1:0] work_q, work_d, work_shift;
    logic [SHW-1:0]  cnt_q, cnt_d;
    logic [3:0]      op_q, op_d;
    logic            is_shift;

    assign is_shift = (bus.alu_sel == ALU_SLL) || (bus.alu_sel == ALU_SRL) ||
                      (bus.alu_sel == ALU_SRA);

    always_comb begin
        case (op_q)
            ALU_SLL: work_shift = work_q << 1;
            ALU_SRA: work_shift = {work_q[XLEN-1], work_q[XLEN-1:1]};
            default: work_shift = work_q >> 1;
        endcase
    end
`endif

    always_comb begin
        // NOTE: every _d starts from its held value so no path through this block infers a latch.
        state_d    = state_q;
        result_d   = result_q;
        zero_d     = zero_q;
        carry_d    = carry_q;
        overflow_d = overflow_q;
        sign_d     = sign_q;
        load       = 1'b0;
`ifndef ALU_FAST_SHIFT_EN
        work_d     = work_q;
        cnt_d      = cnt_q;
        op_d       = op_q;
`endif
        case (state_q)
            S_IDLE: begin
                if (bus.in_valid && in_ready_q) begin
`ifndef ALU_FAST_SHIFT_EN
                    if (is_shift && (shamt != '0)) begin
                        state_d = S_EXEC;
                        work_d  = a;
                        cnt_d   = shamt;
                        op_d    = bus.alu_sel;
                    end else
`endif
                    begin
                        state_d    = S_DONE;
                        result_d   = alu_res;
                        carry_d    = alu_c;
                        overflow_d = alu_v;
                        load       = 1'b1;
                    end
                end
            end
`ifndef ALU_FAST_SHIFT_EN
            S_EXEC: begin
                work_d = work_shift;
                cnt_d  = cnt_q - SHW'(1);
                if (cnt_q == SHW'(1)) begin
                    state_d    = S_DONE;
                    result_d   = work_shift;
                    carry_d    = 1'b0;
                    overflow_d = 1'b0;
                    load       = 1'b1;
                end
            end
`endif
            S_DONE: if (bus.out_ready) state_d = S_IDLE;
            default: state_d = S_IDLE;
        endcase
        if (load) begin
            zero_d = (result_d == '0);
            sign_d = result_d[XLEN-1];
        end
        out_valid_d = (state_d == S_DONE);
        busy_d      = (state_d != S_IDLE);
        in_ready_d  = (state_d == S_IDLE);
    end

    // NOTE: sequential state updates use non-blocking assignments so all flops sample together.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q     <= S_IDLE;
            result_q    <= '0;
            zero_q      <= 1'b0;
            carry_q     <= 1'b0;
            overflow_q  <= 1'b0;
            sign_q      <= 1'b0;
            out_valid_q <= 1'b0;
            busy_q      <= 1'b0;
            in_ready_q  <= 1'b0;
`ifndef ALU_FAST_SHIFT_EN
            work_q      <= '0;
            cnt_q       <= '0;
            op_q        <= '0;
`endif
        end else begin
            state_q     <= state_d;
            result_q    <= result_d;
            zero_q      <= zero_d;
            carry_q     <= carry_d;
            overflow_q  <= overflow_d;
            sign_q      <= sign_d;
            out_valid_q <= out_valid_d;
            busy_q      <= busy_d;
            in_ready_q  <= in_ready_d;
`ifndef ALU_FAST_SHIFT_EN
            work_q      <= work_d;
            cnt_q       <= cnt_d;
            op_q        <= op_d;
`endif
        end
    end

    assign bus.in_ready  = in_ready_q;
    assign bus.out_valid = out_valid_q;
    assign bus.result    = result_q;
    assign bus.zero      = zero_q;
    assign bus.carry     = carry_q;
    assign bus.overflow  = overflow_q;
    assign bus.sign      = sign_q;
    assign bus.busy      = busy_q;
endmodule

// File: tb/tb_alu_exec_unit.sv
// Self-checking bench for alu_exec_unit: directed corner cases plus randomized traffic against a
// behavioural model; honours ALU_FAST_SHIFT_EN for expected latencies.
module tb_alu_exec_unit;
    import alu_exec_pkg::*;

`ifdef ALU_FAST_SHIFT_EN
    localparam bit FAST = 1'b1;
`else
    localparam bit FAST = 1'b0;
`endif
    localparam longint SMAX = 64'sd2147483647;
    localparam longint SMIN = -64'sd2147483648;

    typedef struct {
        logic [31:0] r;
        logic        z, c, v, s;
        int          lat;
        int          acc;
        bit          seen;
    } ent_t;

    logic clk;
    logic rst_n;
    int   n_chk  = 0;
    int   n_fail = 0;
    int   cyc    = 0;
    bit   mon_en = 1'b0;
    bit   rand_rdy = 1'b0;
    bit   forced_rdy = 1'b0;
    ent_t q[$];

    alu_exec_if #(.XLEN(32)) bus ();

    alu_exec_unit #(.XLEN(32), .SHW(5)) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    always @(posedge clk) begin
        #1;
        bus.out_ready = rand_rdy ? ($urandom_range(0, 3) != 0) : forced_rdy;
    end

    initial begin
        #500000;
        $display("FAIL watchdog: simulation did not finish, got t=%0t required completion", $time);
        $fatal(1, "watchdog");
    end

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_chk++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h (t=%0t)", name, act, exp, $time);
        end
    endtask

    // Reference behaviour computed from plain integer arithmetic.
    function automatic ent_t model(input logic [3:0] sel, input logic [31:0] a, input logic [31:0] b);
        ent_t               e;
        longint             sa, sb, ss;
        int                 sh;
        logic signed [31:0] as_;
        e.r = '0; e.c = 1'b0; e.v = 1'b0; e.acc = 0; e.seen = 1'b0;
        sh  = int'(b[4:0]);
        sa  = longint'($signed(a));
        sb  = longint'($signed(b));
        as_ = a;
        case (sel)
            ALU_ADD: begin
                e.r = a + b;
                e.c = (longint'(a) + longint'(b)) >= 64'sh1_0000_0000;
                ss  = sa + sb;
                e.v = (ss > SMAX) || (ss < SMIN);
            end
            ALU_SUB: begin
                e.r = a - b;
                e.c = (a >= b);
                ss  = sa - sb;
                e.v = (ss > SMAX) || (ss < SMIN);
            end
            ALU_SLT:  e.r = (sa < sb) ? 32'd1 : 32'd0;
            ALU_SLTU: e.r = (a < b) ? 32'd1 : 32'd0;
            ALU_AND:  e.r = a & b;
            ALU_OR:   e.r = a | b;
            ALU_XOR:  e.r = a ^ b;
            ALU_SLL:  e.r = a << sh;
            ALU_SRL:  e.r = a >> sh;
            ALU_SRA:  e.r = as_ >>> sh;
            ALU_PASS: e.r = b;
            default:  e.r = '0;
        endcase
        e.z = (e.r == 32'd0);
        e.s = e.r[31];
        if (!FAST && (sel == ALU_SLL || sel == ALU_SRL || sel == ALU_SRA) && sh != 0)
            e.lat = sh + 1;
        else
            e.lat = 1;
        return e;
    endfunction

    // Compare process: whenever out_valid is up, outputs must match the oldest outstanding op.
    always @(negedge clk) begin
        if (mon_en) begin
            if (bus.out_valid) begin
                if (q.size() == 0) begin
                    check("mon_spurious_out_valid", bus.out_valid, 1'b0);
                end else begin
                    check("mon_result", bus.result, q[0].r);
                    check("mon_zero", bus.zero, q[0].z);
                    check("mon_carry", bus.carry, q[0].c);
                    check("mon_overflow", bus.overflow, q[0].v);
                    check("mon_sign", bus.sign, q[0].s);
                    check("mon_in_ready_in_done", bus.in_ready, 1'b0);
                    check("mon_busy_in_done", bus.busy, 1'b1);
                    if (!q[0].seen) begin
                        check("mon_latency", cyc - q[0].acc + 1, q[0].lat);
                        q[0].seen = 1'b1;
                    end
                    if (bus.out_ready) void'(q.pop_front());
                end
            end else if (q.size() > 0 && !q[0].seen && (cyc - q[0].acc) > 40) begin
                check("mon_out_valid_timeout", bus.out_valid, 1'b1);
                void'(q.pop_front());
            end
        end
    end

    task automatic send(input logic [3:0] sel, input logic [31:0] a, input logic [31:0] b);
        ent_t e;
        int   w = 0;
        @(negedge clk);
        while (!bus.in_ready && w < 200) begin
            @(negedge clk);
            w++;
        end
        if (!bus.in_ready) begin
            check("send_in_ready_timeout", bus.in_ready, 1'b1);
            return;
        end
        bus.in_valid = 1'b1;
        bus.alu_sel  = sel;
        bus.op_a     = a;
        bus.op_b     = b;
        @(posedge clk);
        #1;
        e     = model(sel, a, b);
        e.acc = cyc;
        q.push_back(e);
        bus.in_valid = 1'b0;
    endtask

    task automatic finish_xfer(input string name);
        int w = 0;
        @(negedge clk);
        forced_rdy = 1'b1;
        while (bus.out_valid && w < 10) begin
            @(negedge clk);
            w++;
        end
        check({name, "_released"}, bus.out_valid, 1'b0);
        forced_rdy = 1'b0;
    endtask

    // Directed op with literal expectations; also checks busy/in_ready while the op is in flight.
    task automatic run_op(input string name, input logic [3:0] sel, input logic [31:0] a,
                          input logic [31:0] b, input logic [31:0] er, input logic ez,
                          input logic ec, input logic ev, input logic es, input int elat);
        int n = 1;
        send(sel, a, b);
        forever begin
            if (bus.busy !== 1'b1 || bus.in_ready !== 1'b0) begin
                check({name, "_busy"}, bus.busy, 1'b1);
                check({name, "_in_ready"}, bus.in_ready, 1'b0);
            end
            if (bus.out_valid || n > 40) break;
            @(posedge clk);
            #1;
            n++;
        end
        check({name, "_latency"}, n, elat);
        check({name, "_result"}, bus.result, er);
        check({name, "_flags_zcvs"}, {bus.zero, bus.carry, bus.overflow, bus.sign}, {ez, ec, ev, es});
        finish_xfer(name);
    endtask

    function automatic logic [31:0] pick_operand();
        case ($urandom_range(0, 5))
            0: return 32'h0000_0000;
            1: return 32'hFFFF_FFFF;
            2: return 32'h8000_0000;
            3: return 32'h7FFF_FFFF;
            default: return $urandom;
        endcase
    endfunction

    initial begin
        rst_n        = 1'b0;
        bus.in_valid = 1'b0;
        bus.alu_sel  = 4'h0;
        bus.op_a     = '0;
        bus.op_b     = '0;
        repeat (2) @(negedge clk);
        check("rst_out_valid", bus.out_valid, 1'b0);
        check("rst_result", bus.result, 32'h0);
        check("rst_flags_zcvs", {bus.zero, bus.carry, bus.overflow, bus.sign}, 4'b0000);
        check("rst_busy", bus.busy, 1'b0);
        check("rst_in_ready", bus.in_ready, 1'b0);
        rst_n = 1'b1;
        check("release_in_ready_low", bus.in_ready, 1'b0);
        @(posedge clk);
        #1;
        check("release_in_ready_high", bus.in_ready, 1'b1);
        check("release_busy", bus.busy, 1'b0);
        mon_en = 1'b1;

        run_op("add_ovf", ALU_ADD, 32'h7FFF_FFFF, 32'h0000_0001, 32'h8000_0000, 0, 0, 1, 1, 1);
        run_op("add_carry", ALU_ADD, 32'hFFFF_FFFF, 32'h0000_0002, 32'h0000_0001, 0, 1, 0, 0, 1);
        run_op("sub_eq", ALU_SUB, 32'd5, 32'd5, 32'h0, 1, 1, 0, 0, 1);
        run_op("sub_borrow", ALU_SUB, 32'd3, 32'd5, 32'hFFFF_FFFE, 0, 0, 0, 1, 1);
        run_op("sltu", ALU_SLTU, 32'd1, 32'hFFFF_FFFF, 32'h1, 0, 0, 0, 0, 1);
        run_op("slt", ALU_SLT, 32'hFFFF_FFFF, 32'd1, 32'h1, 0, 0, 0, 0, 1);
        run_op("sra31", ALU_SRA, 32'h8000_0000, 32'd31, 32'hFFFF_FFFF, 0, 0, 0, 1, FAST ? 1 : 32);
        run_op("srl4", ALU_SRL, 32'h8000_00F0, 32'd4, 32'h0800_000F, 0, 0, 0, 0, FAST ? 1 : 5);
        run_op("sll0", ALU_SLL, 32'h1, 32'd0, 32'h1, 0, 0, 0, 0, 1);
        run_op("undef_f", 4'hF, 32'h1234_5678, 32'h9ABC_DEF0, 32'h0, 1, 0, 0, 0, 1);
        run_op("pass", ALU_PASS, 32'h1111_1111, 32'hCAFE_F00D, 32'hCAFE_F00D, 0, 0, 0, 1, 1);

        // Backpressure: DONE must hold and ignore new requests until out_ready.
        send(ALU_ADD, 32'h10, 32'h20);
        for (int i = 0; i < 10; i++) begin
            @(negedge clk);
            bus.in_valid = 1'b1;
            bus.alu_sel  = ALU_SUB;
            bus.op_a     = 32'd1;
            bus.op_b     = 32'd1;
            check("hold_in_ready", bus.in_ready, 1'b0);
            check("hold_out_valid", bus.out_valid, 1'b1);
            check("hold_result", bus.result, 32'h30);
        end
        @(negedge clk);
        bus.in_valid = 1'b0;
        forced_rdy   = 1'b1;
        for (int w = 0; w < 10 && bus.out_valid; w++) @(negedge clk);
        check("hold_release_out_valid", bus.out_valid, 1'b0);
        check("hold_release_in_ready", bus.in_ready, 1'b1);
        check("hold_release_busy", bus.busy, 1'b0);
        forced_rdy = 1'b0;
        repeat (3) @(negedge clk);
        check("hold_no_extra_op", bus.out_valid, 1'b0);

        // Reset in the middle of a long shift.
        send(ALU_SRL, 32'hF0F0_F0F0, 32'd20);
        repeat (6) @(posedge clk);
        #2;
        mon_en = 1'b0;
        rst_n  = 1'b0;
        #1;
        q.delete();
        check("midrst_out_valid", bus.out_valid, 1'b0);
        check("midrst_result", bus.result, 32'h0);
        check("midrst_flags_zcvs", {bus.zero, bus.carry, bus.overflow, bus.sign}, 4'b0000);
        check("midrst_busy", bus.busy, 1'b0);
        check("midrst_in_ready", bus.in_ready, 1'b0);
        repeat (2) @(negedge clk);
        rst_n = 1'b1;
        check("midrst_release_in_ready_low", bus.in_ready, 1'b0);
        @(posedge clk);
        #1;
        check("midrst_release_in_ready_high", bus.in_ready, 1'b1);
        mon_en = 1'b1;
        run_op("post_reset_add", ALU_ADD, 32'd2, 32'd3, 32'd5, 0, 0, 0, 0, 1);

        // Randomized traffic with random downstream backpressure.
        rand_rdy = 1'b1;
        for (int i = 0; i < 250; i++) begin
            logic [3:0] sel;
            if ($urandom_range(0, 7) == 0) sel = 4'($urandom_range(11, 15));
            else                           sel = 4'($urandom_range(0, 10));
            send(sel, pick_operand(), pick_operand());
            repeat ($urandom_range(0, 2)) @(negedge clk);
        end
        for (int w = 0; w < 2000 && q.size() != 0; w++) @(negedge clk);
        check("random_drain", q.size(), 0);
        rand_rdy = 1'b0;
        repeat (3) @(negedge clk);

        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end
endmodule
